crc_frame_serializer: RTL

- Upstream stage that feeds the serial CRC-8 generator and collects its result.
- Accepts frame bytes over a valid/ready handshake and serializes them LSB-first onto ACTIVE/DATA with no gaps inside a frame.
- Then releases ACTIVE, captures the 8 serial CRC bits returned on CRC_IN/CRC_VALID, and presents them as a parallel byte.
- Also pulses the CRC generator's active-low reset before every frame so each frame starts from the seed.

---
 rtl/crc_frame_serializer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: feeds frame words bit-serially to a serial CRC-8
// generator, then collects the CRC bits it returns and presents them as a
// parallel byte together with the frame length.
// Optional build macro CRC_SER_MSB_FIRST_EN: serialize each word MSB-first
// (the default build serializes LSB-first). CRC capture order is the same
// in both builds.
module crc_frame_serializer #(
  parameter  int DATA_WIDTH    = 8,
  parameter  int CRC_WIDTH     = 8,
  parameter  int MAX_BYTES     = 16,
  parameter  int DRAIN_TIMEOUT = 16,
  localparam int LEN_W         = $clog2(MAX_BYTES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_LAST,
  output logic                  IN_READY,
  output logic                  ACTIVE,
  output logic                  DATA,
  output logic                  CRC_RST_N,
  input  logic                  CRC_IN,
  input  logic                  CRC_VALID,
  output logic [CRC_WIDTH-1:0]  CRC_OUT,
  output logic                  CRC_OUT_VALID,
  output logic [LEN_W-1:0]      FRAME_LEN,
  output logic                  ERR,
  output logic                  BUSY
);

  localparam int BW  = $clog2(DATA_WIDTH);
  localparam int CCW = $clog2(CRC_WIDTH + 1);
  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  last_q, last_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [CRC_WIDTH-1:0]  crc_sr_q, crc_sr_d;
  logic [CCW-1:0]        crc_cnt_q, crc_cnt_d;
  logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;

  // next values of the registered outputs
  logic                  rdy_d, data_d, err_d;
  logic [CRC_WIDTH-1:0]  crc_out_d;
  logic [LEN_W-1:0]      len_d;
  logic                  hs, word_end, frame_full;

  assign hs         = IN_VALID & IN_READY;
  assign word_end   = (bit_cnt_q == BW'(DATA_WIDTH - 1));
  assign frame_full = (byte_cnt_q == LEN_W'(MAX_BYTES));

  // state and datapath registers; every output is a flop loaded from its next value
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      sr_q          <= '0;
      last_q        <= 1'b0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      crc_sr_q      <= '0;
      crc_cnt_q     <= '0;
      drain_cnt_q   <= '0;
      IN_READY      <= 1'b1;
      ACTIVE        <= 1'b0;
      DATA          <= 1'b0;
      CRC_RST_N     <= 1'b1;
      CRC_OUT       <= '0;
      CRC_OUT_VALID <= 1'b0;
      FRAME_LEN     <= '0;
      ERR           <= 1'b0;
      BUSY          <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      last_q        <= last_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      crc_sr_q      <= crc_sr_d;
      crc_cnt_q     <= crc_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      IN_READY      <= rdy_d;
      ACTIVE        <= (state_d == S_SHIFT);
      DATA          <= data_d;
      CRC_RST_N     <= (state_d != S_CLEAR);
      CRC_OUT       <= crc_out_d;
      CRC_OUT_VALID <= (state_d == S_DONE);
      FRAME_LEN     <= len_d;
      ERR           <= err_d;
      BUSY          <= (state_d != S_IDLE);
    end
  end

  // next-state, datapath and output-next-value logic
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    last_d      = last_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_sr_d    = crc_sr_q;
    crc_cnt_d   = crc_cnt_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = ERR;
    crc_out_d   = CRC_OUT;
    len_d       = FRAME_LEN;
    case (state_q)
      S_IDLE: if (hs) begin
        sr_d       = IN_DATA;
        last_d     = IN_LAST;
        bit_cnt_d  = '0;
        byte_cnt_d = LEN_W'(1);
        err_d      = 1'b0;
        state_d    = S_CLEAR;
      end
      S_CLEAR: begin
        crc_sr_d  = '0;
        crc_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (!word_end) begin
`ifdef CRC_SER_MSB_FIRST_EN
          sr_d = sr_q << 1;
`else
          sr_d = sr_q >> 1;
`endif
          bit_cnt_d = bit_cnt_q + BW'(1);
        end else if (last_q || frame_full) begin
          // a full frame without a last flag is closed as an overflow
          err_d       = err_d | ~last_q;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else if (hs) begin
          // back-to-back word: reload with no gap so ACTIVE stays high
          sr_d       = IN_DATA;
          last_d     = IN_LAST;
          bit_cnt_d  = '0;
          byte_cnt_d = byte_cnt_q + LEN_W'(1);
        end else begin
          // underrun: the CRC covers only the words already sent
          err_d       = 1'b1;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DCW'(1);
        if (CRC_VALID) begin
          crc_sr_d  = {CRC_IN, crc_sr_q[CRC_WIDTH-1:1]};
          crc_cnt_d = crc_cnt_q + CCW'(1);
        end
        if (CRC_VALID && crc_cnt_q == CCW'(CRC_WIDTH - 1)) begin
          state_d = S_DONE;
        end else if (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) begin
      crc_out_d = crc_sr_d;
      len_d     = byte_cnt_d;
    end

    // ready opens in IDLE, or for the one cycle that carries the last bit of a
    // word that is neither flagged last nor the final word a frame can hold
    rdy_d = (state_d == S_IDLE) ||
            (state_q == S_SHIFT && bit_cnt_q == BW'(DATA_WIDTH - 2) &&
             !last_q && !frame_full);

`ifdef CRC_SER_MSB_FIRST_EN
    data_d = (state_d == S_SHIFT) ? sr_d[DATA_WIDTH-1] : 1'b0;
`else
    data_d = (state_d == S_SHIFT) ? sr_d[0] : 1'b0;
`endif
  end

endmodule
